// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative unsigned
// multiply and restoring divide, with results behind a valid/ready handshake.
module alu_mc #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1,
    parameter bit          DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] dataHi,
    output logic             ovf,
    output logic             dbz,
    output logic             illegal
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [5:0] OP_SLL   = 6'd0;
    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_SRA   = 6'd3;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             div_q, div_d, ovf_q, ovf_d, dbz_q, dbz_d, ill_q, ill_d;

    logic [WIDTH-1:0] sum_w, diff_w, mul_addend, div_diff;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic             div_ge;
    logic [SHW-1:0]   shamt;

    // Single-cycle datapath and one iteration step of the multiply/divide
    assign sum_w      = dataA + dataB;
    assign diff_w     = dataA + ~dataB + WIDTH'(1);
    assign shamt      = dataB[SHW-1:0];
    assign mul_addend = lo_q[0] ? b_q : '0;
    assign mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    assign div_sh     = {hi_q, lo_q[WIDTH-1]};
    assign div_ge     = div_sh >= {1'b0, b_q};
    assign div_diff   = div_sh[WIDTH-1:0] - b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_DONE;
                    hi_d    = '0;
                    lo_d    = '0;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    ill_d   = 1'b0;
                    case (Signal)
                        OP_AND: lo_d = dataA & dataB;
                        OP_OR:  lo_d = dataA | dataB;
                        OP_ADD: begin
                            lo_d  = sum_w;
                            ovf_d = (dataA[WIDTH-1] == dataB[WIDTH-1]) &&
                                    (sum_w[WIDTH-1] != dataA[WIDTH-1]);
                        end
                        OP_SUB: begin
                            lo_d  = diff_w;
                            ovf_d = (dataA[WIDTH-1] != dataB[WIDTH-1]) &&
                                    (diff_w[WIDTH-1] != dataA[WIDTH-1]);
                        end
                        OP_SLT: lo_d = ($signed(dataA) < $signed(dataB)) ? WIDTH'(1) : '0;
                        OP_SLL: lo_d = dataA << shamt;
                        OP_SRL: lo_d = dataA >> shamt;
                        OP_SRA: lo_d = WIDTH'($signed(dataA) >>> shamt);
                        OP_MULTU: begin
                            if (MUL_EN) begin
                                lo_d    = dataA;
                                b_d     = dataB;
                                div_d   = 1'b0;
                                cnt_d   = SHW'(WIDTH - 1);
                                state_d = S_BUSY;
                            end else begin
                                ill_d = 1'b1;
                            end
                        end
                        OP_DIVU: begin
                            if (DIV_EN) begin
                                lo_d    = dataA;
                                b_d     = dataB;
                                div_d   = 1'b1;
                                dbz_d   = (dataB == '0);
                                cnt_d   = SHW'(WIDTH - 1);
                                state_d = S_BUSY;
                            end else begin
                                ill_d = 1'b1;
                            end
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            S_BUSY: begin
                // Divide by zero falls out naturally: quotient all ones, remainder = A
                if (div_q) begin
                    hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dataOut   = lo_q;
    assign dataHi    = hi_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;
    assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc at WIDTH=32 with multi-cycle corner sequences.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  Signal;
    logic [31:0] dataA, dataB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dataOut, dataHi;
    logic        ovf, dbz, illegal;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [31:0] hi;
        logic        ovf;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    alu_mc #(.WIDTH(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Signal(Signal), .dataA(dataA), .dataB(dataB), .out_valid(out_valid),
        .out_ready(out_ready), .dataOut(dataOut), .dataHi(dataHi),
        .ovf(ovf), .dbz(dbz), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request from IDLE, return cycles until out_valid; optionally
    // keep a junk ADD request asserted during the first busy cycles.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit junk, output int lat, output bit rdy_busy);
        @(negedge clk);
        Signal = op; dataA = a; dataB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = junk;
        if (junk) begin
            Signal = 6'd32; dataA = 32'd1; dataB = 32'd1;
        end
        lat = 0;
        rdy_busy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_busy = 1'b1;
            if (lat == 10) in_valid = 1'b0;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        bit rb;

        vecs[0]  = '{6'd32, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b1, 1'b0};
        vecs[1]  = '{6'd42, 32'h80000000, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{6'd42, 32'h00000001, 32'h80000000, 32'h00000000, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{6'd3,  32'hF0000000, 32'h00000004, 32'hFF000000, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{6'd0,  32'hF0000000, 32'h00000004, 32'h00000000, 32'h0, 1'b0, 1'b0};
        vecs[5]  = '{6'd2,  32'hF0000000, 32'h00000004, 32'h0F000000, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{6'd37, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{6'd34, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0};
        vecs[9]  = '{6'd34, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{6'd32, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b0};
        vecs[11] = '{6'd63, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{6'd0,  32'h00000001, 32'h00000021, 32'h00000002, 32'h0, 1'b0, 1'b0};
        vecs[13] = '{6'd3,  32'h40000000, 32'h0000001F, 32'h00000000, 32'h0, 1'b0, 1'b0};
        vecs[14] = '{6'd42, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h0, 1'b0, 1'b0};
        vecs[15] = '{6'd42, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Signal = '0; dataA = '0; dataB = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dataOut",   dataOut, 32'd0);
        check("rst_dataHi",    dataHi, 32'd0);
        check("rst_flags",     32'({ovf, dbz, illegal}), 32'd0);

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, rb);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_out", i), dataOut, vecs[i].out);
            check($sformatf("vec%0d_hi", i),  dataHi, vecs[i].hi);
            check($sformatf("vec%0d_flags", i), 32'({ovf, dbz, illegal}),
                  32'({vecs[i].ovf, 1'b0, vecs[i].ill}));
            check($sformatf("vec%0d_rdy_done", i), 32'(in_ready), 32'd0);
            retire();
        end

        // MULTU max*max with junk request held during BUSY; flags from a prior ADD overflow clear
        issue(6'd32, 32'h7FFFFFFF, 32'h1, 1'b0, lat, rb);
        retire();
        issue(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, rb);
        check("mul_lat", 32'(lat), 32'd33);
        check("mul_rdy_busy", 32'(rb), 32'd0);
        check("mul_lo", dataOut, 32'h00000001);
        check("mul_hi", dataHi, 32'hFFFFFFFE);
        check("mul_flags", 32'({ovf, dbz, illegal}), 32'd0);
        retire();
        @(negedge clk);
        check("mul_junk_ignored", 32'(out_valid), 32'd0);
        check("mul_rdy_after", 32'(in_ready), 32'd1);

        issue(6'd25, 32'h12345678, 32'h00000010, 1'b0, lat, rb);
        check("mul2_lo", dataOut, 32'h23456780);
        check("mul2_hi", dataHi, 32'h00000001);
        retire();

        issue(6'd27, 32'd100, 32'd7, 1'b0, lat, rb);
        check("div_lat", 32'(lat), 32'd33);
        check("div_q", dataOut, 32'd14);
        check("div_r", dataHi, 32'd2);
        check("div_dbz", 32'(dbz), 32'd0);
        retire();

        issue(6'd27, 32'd100, 32'd0, 1'b0, lat, rb);
        check("dbz_lat", 32'(lat), 32'd33);
        check("dbz_q", dataOut, 32'hFFFFFFFF);
        check("dbz_r", dataHi, 32'd100);
        check("dbz_flag", 32'(dbz), 32'd1);
        retire();

        issue(6'd27, 32'hFFFFFFFF, 32'h00010000, 1'b0, lat, rb);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_q", k), dataOut, 32'h0000FFFF);
            check($sformatf("stall%0d_r", k), dataHi, 32'h0000FFFF);
        end
        retire();
        @(negedge clk);
        check("stall_retired", 32'(out_valid), 32'd0);
        check("stall_rdy", 32'(in_ready), 32'd1);

        // Reset in the middle of a multiply abandons it
        Signal = 6'd25; dataA = 32'd3; dataB = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_out", dataOut, 32'd0);
        check("midrst_hi", dataHi, 32'd0);
        check("midrst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_result", 32'(out_valid), 32'd0);
        issue(6'd32, 32'd2, 32'd3, 1'b0, lat, rb);
        check("postrst_lat", 32'(lat), 32'd1);
        check("postrst_out", dataOut, 32'd5);
        retire();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 32-bit combinational ALU. It keeps the same function-code encoding and adds the following:
  - signed overflow detection;
  - shift ops;
  - iterative unsigned multiply and divide;
  - registered results behind a valid/ready handshake.
- It sits between the decode/operand-fetch stage and writeback. One operation is in flight at a time.

Parameters:
- WIDTH, 32: operand/result width in bits (>=4).
- MUL_EN, 1: 1 = MULTU implemented; 0 = MULTU treated as illegal opcode.
- DIV_EN, 1: 1 = DIVU implemented; 0 = DIVU treated as illegal opcode.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request strobe.
- in_ready  output  1  block can accept a request.
- Signal  input  6  function code.
- dataA  input  WIDTH  operand A; also shift source.
- dataB  input  WIDTH  operand B; shift amount in low log2(WIDTH) bits.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- dataOut  output  WIDTH  result; low product for MULTU; quotient for DIVU.
- dataHi  output  WIDTH  high product for MULTU; remainder for DIVU; 0 otherwise.
- ovf  output  1  signed overflow (ADD/SUB only).
- dbz  output  1  divide by zero (DIVU only).
- illegal  output  1  unsupported function code.

Behaviour:
- Function codes (decimal):
  - AND 36, OR 37, ADD 32, SUB 34, SLT 42;
  - SLL 0, SRL 2, SRA 3;
  - MULTU 25, DIVU 27.
- Reset (reset=0, async):
  - state=IDLE;
  - out_valid, dataOut, dataHi, ovf, dbz, illegal all 0;
  - in_ready=1 after reset release;
  - any in-flight operation is abandoned.
- States:
  - IDLE: in_ready=1. On in_valid, operands and Signal are captured.
    - Single-cycle op or illegal code -> DONE.
    - MULTU/DIVU -> BUSY, iteration counter=WIDTH-1.
  - BUSY: in_ready=0. One shift-add (MULTU) or restoring-subtract (DIVU) step per cycle. Counter decrements; at 0 -> DONE. inputs are ignored during BUSY.
  - DONE: out_valid=1, outputs held stable. When out_ready=1 -> IDLE at the next edge. in_ready=0 in DONE; there is no overlap of accept and retire.
- Latency, from accept edge to out_valid=1:
  - single-cycle ops: 1 cycle;
  - MULTU/DIVU: WIDTH+1 cycles.
  - Throughput is at best one op per 2 cycles.
- Arithmetic:
  - All results are registered, wraps modulo 2^WIDTH.
  - ADD/SUB: ovf = signed overflow. SUB = A + ~B + 1.
  - SLT: dataOut = 1 if signed A < signed B, else 0. Correct across overflow, e.g. A=most-negative, B=1 -> 1.
  - SLL/SRL/SRA: shift amount = dataB[log2(WIDTH)-1:0]. SRA replicates dataA[WIDTH-1].
  - MULTU: {dataHi,dataOut} = unsigned A*B, full 2*WIDTH bits.
  - DIVU: dataOut = A/B, dataHi = A%B, both unsigned.
- Divide by zero (B=0, DIVU): still takes WIDTH+1 cycles; dataOut = all ones, dataHi = dataA, dbz=1.
- Illegal code (incl. MULTU with MUL_EN=0, DIVU with DIV_EN=0): dataOut=0, dataHi=0, illegal=1, latency 1.
- Flags ovf/dbz/illegal are valid only while out_valid=1 and are cleared on the next accept.
- in_valid while in_ready=0 is ignored; no buffering. Requester must hold in_valid until it sees in_ready=1 at a clock edge.
- out_ready=0 stalls indefinitely in DONE with outputs stable.
- Reset asserted mid-BUSY or mid-DONE: immediate return to reset values; no result is emitted.

Test Plan:
- Reset release, then in_valid, Signal=32, A=0x7FFFFFFF, B=1 -> next cycle out_valid=1, dataOut=0x80000000, ovf=1, dataHi=0.
- Signal=42, A=0x80000000, B=0x00000001 -> dataOut=1.
- Swap the operands (A=0x00000001, B=0x80000000) -> dataOut=0.
- Signal=3, A=0xF0000000, B=4 -> dataOut=0xFF000000.
- Signal=0, same operands -> dataOut=0x00000000.
- Signal=25, A=0xFFFFFFFF, B=0xFFFFFFFF:
  - out_valid rises exactly 33 cycles after accept, dataHi=0xFFFFFFFE, dataOut=0x00000001;
  - in_ready=0 throughout;
  - a second in_valid during BUSY is ignored.
- Signal=27, A=100, B=7 -> after 33 cycles dataOut=14, dataHi=2.
- Signal=27, A=100, B=0 -> after 33 cycles dataOut=0xFFFFFFFF, dataHi=100, dbz=1.
- Signal=27 with out_ready=0 for 5 cycles after out_valid -> outputs hold; retire on out_ready=1, in_ready=1 the next cycle.
- Signal=25 issued, then reset=0 at cycle 10 -> outputs 0 immediately, state IDLE.
- Signal=63 -> illegal=1, dataOut=0.
